// File: rtl/mem_interface_unit.sv
// mem_interface_unit: MAR/MDR registers, big-endian byte RAM and MOV/MOC handshake
// with byte/halfword/word access, sign/zero extension and configurable wait states.
module mem_interface_unit #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] ALU_IN,
    input  logic              MAR_LD,
    input  logic              MDR_LD,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        SIZE,
    input  logic              SIGNED,
    output logic [ADDR_W-1:0] MAR_Q,
    output logic [DATA_W-1:0] MDR_Q,
    output logic              MOC,
    output logic              ERR
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic              op_rw, op_signed;
    logic [1:0]        op_size;
    logic [ADDR_W-1:0] op_addr;
    logic [7:0]        mem [DEPTH];
    logic [AW-1:0]     ia [4];
    logic [2:0]        nbytes;
    logic [ADDR_W:0]   end_addr;
    logic [31:0]       rd_word;
    logic [DATA_W-1:0] rd_val;
    logic              err, access, idle;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE)      state_nx = MOV ? BUSY : IDLE;
        else if (state == BUSY) state_nx = cnt == '0 ? ACK : BUSY;
        else                    state_nx = MOV ? ACK : IDLE;
    end

    always_comb begin
        idle   = state == IDLE;
        access = state == BUSY && cnt == '0;
    end

    // Byte lanes of the addressed location, most significant first.
    always_comb begin
        for (int k = 0; k < 4; k++) ia[k] = op_addr[AW-1:0] + AW'(k);
        nbytes   = op_size == 2'b00 ? 3'd1 : op_size == 2'b01 ? 3'd2 : 3'd4;
        end_addr = {1'b0, op_addr} + (ADDR_W+1)'(nbytes);
        err      = op_size == 2'b11 || (op_size == 2'b01 && op_addr[0]) ||
                   (op_size == 2'b10 && op_addr[1:0] != 2'b00) ||
                   end_addr > (ADDR_W+1)'(DEPTH);
        rd_word  = {mem[ia[0]], mem[ia[1]], mem[ia[2]], mem[ia[3]]};
        rd_val   = op_size == 2'b00 ? {{24{op_signed & rd_word[31]}}, rd_word[31:24]} :
                   op_size == 2'b01 ? {{16{op_signed & rd_word[31]}}, rd_word[31:16]} :
                   rd_word;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt       <= '0;
            MAR_Q     <= '0;
            MDR_Q     <= '0;
            MOC       <= 1'b0;
            ERR       <= 1'b0;
            op_rw     <= 1'b0;
            op_size   <= 2'b00;
            op_signed <= 1'b0;
            op_addr   <= '0;
        end else begin
            if (idle && MAR_LD) MAR_Q <= ADDR_W'(ALU_IN);
            if (idle && MDR_LD) MDR_Q <= ALU_IN;
            else if (access && op_rw && !err) MDR_Q <= rd_val;
            if (idle && MOV) begin
                op_rw     <= RW;
                op_size   <= SIZE;
                op_signed <= SIGNED;
                op_addr   <= MAR_Q;
                cnt       <= CW'(WAIT_CYCLES);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (access) begin
                MOC <= 1'b1;
                ERR <= err;
            end else if (state == ACK && !MOV) begin
                MOC <= 1'b0;
                ERR <= 1'b0;
            end
        end
    end

    // RAM is not reset; a write only commits on the edge entering ACK.
    always_ff @(posedge CLK) begin
        if (access && !op_rw && !err) begin
            if (op_size == 2'b00) begin
                mem[ia[0]] <= MDR_Q[7:0];
            end else if (op_size == 2'b01) begin
                mem[ia[0]] <= MDR_Q[15:8];
                mem[ia[1]] <= MDR_Q[7:0];
            end else begin
                mem[ia[0]] <= MDR_Q[31:24];
                mem[ia[1]] <= MDR_Q[23:16];
                mem[ia[2]] <= MDR_Q[15:8];
                mem[ia[3]] <= MDR_Q[7:0];
            end
        end
    end
endmodule

// File: tb/tb_mem_interface_unit.sv
// tb_mem_interface_unit: scoreboard bench; driver queues expected completions,
// a negedge monitor checks each MOC rise. A WAIT_CYCLES=0 copy checks short latency.
module tb_mem_interface_unit;
    logic        CLK = 1'b0, RESET_N = 1'b0;
    logic [31:0] ALU_IN = '0;
    logic        MAR_LD = 1'b0, MDR_LD = 1'b0, MOV = 1'b0, RW = 1'b0, SIGNED = 1'b0;
    logic [1:0]  SIZE = 2'b00;
    logic [31:0] MAR_Q, MDR_Q, MAR_Q1, MDR_Q1;
    logic        MOC, ERR, MOC1, ERR1;

    mem_interface_unit #(.WAIT_CYCLES(2)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ALU_IN(ALU_IN), .MAR_LD(MAR_LD), .MDR_LD(MDR_LD),
        .MOV(MOV), .RW(RW), .SIZE(SIZE), .SIGNED(SIGNED),
        .MAR_Q(MAR_Q), .MDR_Q(MDR_Q), .MOC(MOC), .ERR(ERR));

    mem_interface_unit #(.WAIT_CYCLES(0)) dut0w (
        .CLK(CLK), .RESET_N(RESET_N), .ALU_IN(ALU_IN), .MAR_LD(MAR_LD), .MDR_LD(MDR_LD),
        .MOV(MOV), .RW(RW), .SIZE(SIZE), .SIGNED(SIGNED),
        .MAR_Q(MAR_Q1), .MDR_Q(MDR_Q1), .MOC(MOC1), .ERR(ERR1));

    always #5 CLK = ~CLK;

    typedef struct {
        logic        err;
        logic [31:0] mdr;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0, edges = 0;
    logic [31:0] mar_m = '0, mdr_m = '0;
    logic        moc_prev = 1'b0;

    always @(posedge CLK) edges <= edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every MOC rise on the WAIT_CYCLES=2 unit consumes one expectation.
    always @(negedge CLK) begin
        if (MOC && !moc_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_moc: got MOC=1 expected no pending op");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("err", {31'b0, ERR}, {31'b0, e.err});
                chk("mdr", MDR_Q, e.mdr);
                chk("latency", edges - e.acc, 3);
            end
        end
        moc_prev = MOC;
    end

    task automatic ld_mar(input logic [31:0] v);
        ALU_IN = v; MAR_LD = 1'b1;
        @(negedge CLK);
        MAR_LD = 1'b0; mar_m = v;
    endtask

    task automatic ld_mdr(input logic [31:0] v);
        ALU_IN = v; MDR_LD = 1'b1;
        @(negedge CLK);
        MDR_LD = 1'b0; mdr_m = v;
    endtask

    task automatic op(input logic rw, input logic [1:0] size, input logic sgn,
                      input logic exp_err, input logic [31:0] exp_mdr,
                      input int hold, input logic pulse);
        exp_t e;
        int   n;
        MOV = 1'b1; RW = rw; SIZE = size; SIGNED = sgn;
        @(posedge CLK);
        #1;
        e.err = exp_err; e.mdr = exp_mdr; e.acc = edges;
        sb.push_back(e);
        chk("moc_w0_accept", {31'b0, MOC1}, 0);
        @(negedge CLK);
        if (pulse) begin
            ALU_IN = 32'hFFFF_FFF0; MAR_LD = 1'b1;
        end
        @(posedge CLK);
        #1;
        chk("moc_w0_latency", {31'b0, MOC1}, 1);
        @(negedge CLK);
        MAR_LD = 1'b0;
        n = 0;
        while (!MOC && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!MOC) begin
            checks++;
            errors++;
            $display("FAIL moc_timeout: got MOC=0 expected MOC=1 within 20 cycles");
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk("moc_hold", {31'b0, MOC}, 1);
        end
        MOV = 1'b0;
        @(posedge CLK);
        #1;
        chk("moc_drop", {31'b0, MOC}, 0);
        chk("err_drop", {31'b0, ERR}, 0);
        @(negedge CLK);
        if (hold > 0)
            for (int i = 0; i < 4; i++) begin
                @(negedge CLK);
                chk("no_second_op", {31'b0, MOC}, 0);
            end
        if (pulse) chk("mar_ignored", MAR_Q, mar_m);
        mdr_m = exp_mdr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_mar", MAR_Q, 0);
        chk("rst_mdr", MDR_Q, 0);
        chk("rst_moc", {31'b0, MOC}, 0);
        chk("rst_err", {31'b0, ERR}, 0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // word round trip, with held MOV and a MAR_LD pulse during BUSY
        ld_mar(32'h10); ld_mdr(32'hDEAD_BEEF);
        op(1'b0, 2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, 5, 1'b1);
        ld_mdr(32'h0);
        op(1'b1, 2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);

        // extension: RAM[0x20]=0x80, RAM[0x21]=0x01
        ld_mar(32'h20); ld_mdr(32'h0000_8001);
        op(1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_8001, 0, 1'b0);
        op(1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0080, 0, 1'b0);
        op(1'b1, 2'b00, 1'b1, 1'b0, 32'hFFFF_FF80, 0, 1'b0);
        op(1'b1, 2'b01, 1'b1, 1'b0, 32'hFFFF_8001, 0, 1'b0);
        op(1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_8001, 0, 1'b0);
        ld_mar(32'h21);
        op(1'b1, 2'b00, 1'b1, 1'b0, 32'h0000_0001, 0, 1'b0);

        // byte lane write
        ld_mar(32'h30); ld_mdr(32'h1122_3344);
        op(1'b0, 2'b10, 1'b0, 1'b0, 32'h1122_3344, 0, 1'b0);
        ld_mar(32'h32); ld_mdr(32'h0000_00AA);
        op(1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_00AA, 0, 1'b0);
        ld_mar(32'h30);
        op(1'b1, 2'b10, 1'b0, 1'b0, 32'h1122_AA44, 0, 1'b0);

        // errors leave MDR and RAM untouched
        ld_mar(32'h31);
        op(1'b1, 2'b10, 1'b0, 1'b1, 32'h1122_AA44, 0, 1'b0);
        op(1'b1, 2'b01, 1'b0, 1'b1, 32'h1122_AA44, 0, 1'b0);
        op(1'b1, 2'b11, 1'b0, 1'b1, 32'h1122_AA44, 0, 1'b0);
        ld_mar(32'd252); ld_mdr(32'h0102_0304);
        op(1'b0, 2'b10, 1'b0, 1'b0, 32'h0102_0304, 0, 1'b0);
        ld_mar(32'd254); ld_mdr(32'hCAFE_F00D);
        op(1'b0, 2'b10, 1'b0, 1'b1, 32'hCAFE_F00D, 0, 1'b0);
        op(1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_0304, 0, 1'b0);
        ld_mar(32'd255);
        op(1'b1, 2'b01, 1'b0, 1'b1, 32'h0000_0304, 0, 1'b0);
        op(1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0004, 0, 1'b0);
        ld_mar(32'd256);
        op(1'b1, 2'b00, 1'b0, 1'b1, 32'h0000_0004, 0, 1'b0);

        // reset during BUSY aborts the write
        ld_mar(32'h40); ld_mdr(32'h0000_005A);
        op(1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_005A, 0, 1'b0);
        ld_mdr(32'h0000_00A5);
        MOV = 1'b1; RW = 1'b0; SIZE = 2'b00;
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        chk("abort_moc", {31'b0, MOC}, 0);
        chk("abort_mar", MAR_Q, 0);
        chk("abort_mdr", MDR_Q, 0);
        MOV = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1; mar_m = '0; mdr_m = '0;
        @(negedge CLK);
        ld_mar(32'h40);
        op(1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_005A, 0, 1'b0);
        ld_mdr(32'h0000_00A5);
        op(1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_00A5, 0, 1'b0);
        ld_mdr(32'h0);
        op(1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_00A5, 0, 1'b0);

        repeat (4) @(negedge CLK);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_interface_unit.md
Name: mem_interface_unit

Overview:
- Memory-side block for datapath phase 2. It holds the MAR and MDR registers and a byte-addressable big-endian RAM.
- It runs the MOV/MOC handshake with the control unit and supports byte, halfword and word access, sign or zero extension, and parametrised wait states.
- It connects between the ALU output, the control-unit load strobes, and the MDR path into the register file/ALU muxes.

Parameters:
- ADDR_W, 32, width of MAR and address compare
- DATA_W, 32, width of MDR and ALU_IN (fixed at 32 for word mode)
- DEPTH, 256, RAM size in bytes; valid addresses 0..DEPTH-1
- WAIT_CYCLES, 2, wait states inserted before each access (0 allowed)

Ports:
- CLK  input  1  system clock, rising edge
- RESET_N  input  1  asynchronous active-low reset
- ALU_IN  input  DATA_W  ALU result; source for MAR and MDR
- MAR_LD  input  1  load MAR from ALU_IN
- MDR_LD  input  1  load MDR from ALU_IN
- MOV  input  1  memory operation valid, from control unit
- RW  input  1  1 = read, 0 = write; sampled when MOV is accepted
- SIZE  input  2  00 byte, 01 halfword, 10 word, 11 reserved (flagged as error)
- SIGNED  input  1  sign-extend byte/halfword reads
- MAR_Q  output  ADDR_W  current MAR
- MDR_Q  output  DATA_W  current MDR
- MOC  output  1  memory operation complete
- ERR  output  1  access error, valid while MOC=1

Behaviour:
- Reset (RESET_N=0, async): MAR_Q=0, MDR_Q=0, MOC=0, ERR=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - MAR_LD/MDR_LD load on the clock edge.
  - If MOV=1: latch RW, SIZE, SIGNED and MAR into an op register, load counter=WAIT_CYCLES, go to BUSY.
  - If MOV=1 and MAR_LD are asserted in the same cycle, the op uses the old MAR value.
- BUSY:
  - Counter>0: decrement and stay.
  - Counter==0: perform the access, set MOC=1, go to ACK.
  - Latency: MOC rises WAIT_CYCLES+1 edges after the edge that accepted MOV.
- ACK:
  - MOC=1 held while MOV=1.
  - MOV=0: MOC=0 and ERR=0 on the next edge, return to IDLE.
  - A new op is accepted only from IDLE, so each op needs at least one MOV-low cycle.
- MAR_LD/MDR_LD in BUSY or ACK are ignored. MDR is owned by the memory op until MOC has dropped.
- Endianness: big-endian. Word at A: RAM[A]=bits 31:24 ... RAM[A+3]=bits 7:0. Halfword at A: RAM[A]=bits 15:8.
- Writes (RW=0):
  - Byte writes MDR[7:0]; halfword writes MDR[15:0]; word writes the full MDR.
  - The RAM is updated on the edge entering ACK. MDR is unchanged.
- Reads (RW=1):
  - MDR is loaded on the edge entering ACK.
  - Byte and halfword reads are zero-extended, or sign-extended when SIGNED=1.
- Error conditions, checked at the access point:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - SIZE=11.
  - Address plus access size exceeds DEPTH.
- On error: ERR=1 with MOC=1, no RAM write, MDR is not modified by reads, and the handshake completes normally.
- Reset asserted in BUSY aborts the op with no RAM write. Reset asserted in ACK leaves a completed write committed.
- WAIT_CYCLES=0: BUSY lasts exactly one cycle.

Test Plan:
- Word write/read round trip: WAIT_CYCLES=2. MAR←0x10, MDR←0xDEADBEEF, MOV=1 RW=0 SIZE=10 → MOC=1 exactly 3 edges after acceptance, RAM[0x10..0x13]=DE,AD,BE,EF. Then clear MDR, read → MDR_Q=0xDEADBEEF, ERR=0.
- Byte/halfword extension: RAM[0x20]=0x80, RAM[0x21]=0x01.
  - Byte read SIGNED=0 → 0x00000080; SIGNED=1 → 0xFFFFFF80.
  - Halfword read at 0x20 with SIGNED=1 → 0xFFFF8001.
- Byte write lane: word 0x11223344 at 0x30, then byte write of 0xAA at 0x32 → word read at 0x30 = 0x1122AA44.
- Errors:
  - Word read at 0x31 → MOC=1, ERR=1, MDR unchanged.
  - Word write at DEPTH-2=254 → ERR=1, RAM[254..255] unchanged.
  - ERR and MOC both drop one edge after MOV=0.
- Handshake and ignore rules: hold MOV=1 for 5 cycles after MOC → MOC stays 1 and no second op starts. MAR_LD pulsed in BUSY → MAR_Q unchanged.
- Reset mid-op: write to 0x40 started, RESET_N=0 during BUSY → MOC=0, MAR_Q=0 immediately, RAM[0x40] keeps its prior value. Repeat the write with WAIT_CYCLES=0 → MOC rises 1 edge after acceptance.
